// File: rtl/ps2io.sv
// PS/2 host receiver: synchronizes and filters the device lines, deframes
// 11-bit frames and queues bytes in a FIFO behind a 4-register CPU port.
module ps2io #(
  parameter int FIFO_DEPTH = 8,
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] AD,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       rw,
  input  logic       cs,
  output logic       irq,
  input  logic       ps2clk,
  input  logic       ps2dat
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FILTER_LEN) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PAR,
    S_STOP
  } state_e;

  logic [1:0]    csync_q, dsync_q;
  logic [FW-1:0] cfc_q, dfc_q;
  logic          cflt_q, dflt_q, cprev_q;
  logic          fall;

  state_e        state_q, state_d;
  logic [7:0]    shift_q;
  logic [2:0]    bit_q;
  logic          par_q;
  logic [TW-1:0] to_q;
  logic          to_hit;
  logic          push, perr_set, ferr_set, ovr_set;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic          full, nempty, pop, flush, do_push;
  logic          wr, rd;

  logic [2:0]    err_q, err_d, clr;
  logic          rx_en_q, irq_en_q, irq_q;
  logic          unused_di;

  assign unused_di = ^DI[6:5];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csync_q <= 2'b11;
      dsync_q <= 2'b11;
    end else begin
      csync_q <= {csync_q[0], ps2clk};
      dsync_q <= {dsync_q[0], ps2dat};
    end
  end

  // Level flips only after FILTER_LEN consecutive disagreeing samples
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cflt_q  <= 1'b1;
      dflt_q  <= 1'b1;
      cprev_q <= 1'b1;
      cfc_q   <= '0;
      dfc_q   <= '0;
    end else begin
      cprev_q <= cflt_q;
      if (csync_q[1] == cflt_q) begin
        cfc_q <= '0;
      end else if (cfc_q == FW'(FILTER_LEN - 1)) begin
        cflt_q <= csync_q[1];
        cfc_q  <= '0;
      end else begin
        cfc_q <= cfc_q + 1'b1;
      end
      if (dsync_q[1] == dflt_q) begin
        dfc_q <= '0;
      end else if (dfc_q == FW'(FILTER_LEN - 1)) begin
        dflt_q <= dsync_q[1];
        dfc_q  <= '0;
      end else begin
        dfc_q <= dfc_q + 1'b1;
      end
    end
  end

  assign fall = cprev_q & ~cflt_q;

  assign to_hit = (state_q != S_IDLE) && !fall &&
                  (to_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!rx_en_q || to_hit) begin
      state_d = S_IDLE;
    end else if (fall) begin
      case (state_q)
        S_IDLE:  if (!dflt_q) state_d = S_DATA;
        S_DATA:  if (bit_q == 3'd7) state_d = S_PAR;
        S_PAR:   state_d = S_STOP;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    push     = 1'b0;
    perr_set = 1'b0;
    ferr_set = 1'b0;
    if (rx_en_q) begin
      if (to_hit) begin
        ferr_set = 1'b1;
      end else if (fall) begin
        case (state_q)
          S_IDLE: ferr_set = dflt_q;
          S_STOP: begin
            if (!dflt_q) ferr_set = 1'b1;
            else if (~^{shift_q, par_q}) perr_set = 1'b1;
            else push = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
      to_q    <= '0;
    end else begin
      if (state_q == S_IDLE || fall) to_q <= '0;
      else to_q <= to_q + 1'b1;
      if (state_q == S_IDLE) bit_q <= '0;
      if (fall && state_q == S_DATA) begin
        shift_q <= {dflt_q, shift_q[7:1]};
        bit_q   <= bit_q + 1'b1;
      end
      if (fall && state_q == S_PAR) par_q <= dflt_q;
    end
  end

  assign wr      = cs & ~rw;
  assign rd      = cs & rw;
  assign nempty  = cnt_q != '0;
  assign full    = cnt_q == CW'(FIFO_DEPTH);
  assign pop     = rd && AD == 2'd0 && nempty;
  assign flush   = wr && AD == 2'd2 && DI[7];
  assign do_push = push & ~flush & (~full | pop);
  assign ovr_set = push & full & ~pop & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (pop) rp_q <= rp_q + 1'b1;
      case ({do_push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= shift_q;
  end

  // New error events beat a same-cycle W1C
  assign clr   = (wr && AD == 2'd1) ? DI[4:2] : 3'b000;
  assign err_d = (err_q & ~clr) | {ferr_set, perr_set, ovr_set};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q    <= '0;
      rx_en_q  <= 1'b1;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      err_q <= err_d;
      if (wr && AD == 2'd2) begin
        rx_en_q  <= DI[0];
        irq_en_q <= DI[1];
      end
      irq_q <= irq_en_q & (nempty | (|err_q));
    end
  end

  assign irq = irq_q;

  always_comb begin
    DO = 8'h00;
    unique case (AD)
      2'd0: DO = nempty ? mem_q[rp_q] : 8'h00;
      2'd1: DO = {irq_q, 1'b0, state_q != S_IDLE,
                  err_q, full, nempty};
      2'd2: DO = {6'b0, irq_en_q, rx_en_q};
      2'd3: DO = 8'(cnt_q);
    endcase
  end

endmodule

// File: tb/tb_ps2io.sv
// Directed bench for ps2io: drives PS/2 frames and checks the
// register view against hand-computed values.
module tb_ps2io;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] AD = 2'd0;
  logic [7:0] DI = 8'h00;
  logic [7:0] DO;
  logic       rw = 1'b0;
  logic       cs = 1'b0;
  logic       irq;
  logic       ps2clk = 1'b1;
  logic       ps2dat = 1'b1;

  int n_chk = 0;
  int n_fail = 0;

  ps2io dut (
    .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(DO),
    .rw(rw), .cs(cs), .irq(irq),
    .ps2clk(ps2clk), .ps2dat(ps2dat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; rw = 1'b1; AD = a;
    #1 d = DO;
    @(negedge clk);
    cs = 1'b0; rw = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] v);
    @(negedge clk);
    cs = 1'b1; rw = 1'b0; AD = a; DI = v;
    @(negedge clk);
    cs = 1'b0; DI = 8'h00;
  endtask

  task automatic chk_rd(input string tag, input logic [1:0] a,
                        input logic [7:0] exp);
    logic [7:0] d;
    rd(a, d);
    chk(tag, d, exp);
  endtask

  // 80-clk PS/2 bit period; optional 2-clk glitches on each half
  task automatic send_bits(input logic [10:0] fr, input int nb,
                           input bit glitch);
    for (int i = 0; i < nb; i++) begin
      ps2dat = fr[i];
      cyc(20);
      ps2clk = 1'b0;
      if (glitch) begin
        cyc(15); ps2clk = 1'b1; cyc(2); ps2clk = 1'b0; cyc(23);
      end else begin
        cyc(40);
      end
      ps2clk = 1'b1;
      if (glitch) begin
        cyc(8); ps2clk = 1'b0; cyc(2); ps2clk = 1'b1; cyc(10);
      end else begin
        cyc(20);
      end
    end
  endtask

  task automatic send(input logic [7:0] b, input bit badpar,
                      input bit glitch);
    send_bits({1'b1, (~^b) ^ badpar, b, 1'b0}, 11, glitch);
    cyc(10);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(5);
    rst = 1'b1;
    cyc(5);

    chk_rd("rst_status", 2'd1, 8'h00);
    chk_rd("rst_ctrl", 2'd2, 8'h01);
    chk_rd("rst_count", 2'd3, 8'h00);
    chk_rd("rst_data", 2'd0, 8'h00);
    chk("rst_irq", {7'b0, irq}, 8'h00);

    send(8'h1C, 1'b0, 1'b0);
    chk_rd("f1c_count", 2'd3, 8'h01);
    chk_rd("f1c_status", 2'd1, 8'h01);
    chk_rd("f1c_data", 2'd0, 8'h1C);
    chk_rd("f1c_count0", 2'd3, 8'h00);
    chk_rd("f1c_status0", 2'd1, 8'h00);

    send(8'h1C, 1'b1, 1'b0);
    chk_rd("perr_count", 2'd3, 8'h00);
    chk_rd("perr_status", 2'd1, 8'h08);
    wr(2'd1, 8'h08);
    chk_rd("perr_clr", 2'd1, 8'h00);

    for (int i = 1; i <= 9; i++) send(8'(i), 1'b0, 1'b0);
    chk_rd("ovr_count", 2'd3, 8'h08);
    chk_rd("ovr_status", 2'd1, 8'h07);
    for (int i = 1; i <= 8; i++) chk_rd("ovr_data", 2'd0, 8'(i));
    chk_rd("ovr_count0", 2'd3, 8'h00);
    wr(2'd1, 8'h04);
    chk_rd("ovr_clr", 2'd1, 8'h00);

    send_bits({1'b1, 1'b1, 8'h33, 1'b0}, 5, 1'b0);
    chk_rd("to_busy", 2'd1, 8'h20);
    cyc(2000);
    chk_rd("to_status", 2'd1, 8'h10);
    send(8'h5A, 1'b0, 1'b0);
    chk_rd("to_count", 2'd3, 8'h01);
    chk_rd("to_data", 2'd0, 8'h5A);
    wr(2'd1, 8'h10);
    chk_rd("to_clr", 2'd1, 8'h00);

    wr(2'd2, 8'h03);
    chk_rd("irq_ctrl", 2'd2, 8'h03);
    @(negedge clk);
    AD = 2'd3;
    fork
      send(8'hF0, 1'b0, 1'b0);
      begin
        for (int k = 0; k < 3000 && DO !== 8'h01; k++) @(negedge clk);
        chk("irq_push_seen", DO, 8'h01);
        chk("irq_at_push", {7'b0, irq}, 8'h00);
        @(negedge clk);
        chk("irq_after_push", {7'b0, irq}, 8'h01);
      end
    join
    chk_rd("irq_data", 2'd0, 8'hF0);
    chk("irq_at_pop", {7'b0, irq}, 8'h01);
    cyc(1);
    chk("irq_after_pop", {7'b0, irq}, 8'h00);
    wr(2'd2, 8'h01);

    send(8'hAA, 1'b0, 1'b1);
    chk_rd("glitch_count", 2'd3, 8'h01);
    chk_rd("glitch_status", 2'd1, 8'h01);
    chk_rd("glitch_data", 2'd0, 8'hAA);

    send(8'h11, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b0);
    chk_rd("flush_pre", 2'd3, 8'h02);
    wr(2'd2, 8'h81);
    chk_rd("flush_count", 2'd3, 8'h00);
    chk_rd("flush_ctrl", 2'd2, 8'h01);

    wr(2'd2, 8'h00);
    send(8'h44, 1'b0, 1'b0);
    chk_rd("rxoff_count", 2'd3, 8'h00);
    chk_rd("rxoff_status", 2'd1, 8'h00);
    wr(2'd2, 8'h03);

    send_bits({1'b1, 1'b1, 8'h33, 1'b0}, 4, 1'b0);
    rst = 1'b0;
    cyc(3);
    rst = 1'b1;
    ps2dat = 1'b1;
    cyc(3);
    chk_rd("mrst_status", 2'd1, 8'h00);
    chk_rd("mrst_ctrl", 2'd2, 8'h01);
    chk_rd("mrst_count", 2'd3, 8'h00);
    chk("mrst_irq", {7'b0, irq}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
